run_monitor: RTL and testbench
==============================

// Module: run_monitor
// PURPOSE
//   Parametrised execution monitor for the PseudoCPU top level. Gates the core's
//   run enable, counts cycles and fetches, and ends a run on one of three events:
//   HALT_ADDR fetch, self-loop stall, or watchdog timeout. On run end, snapshots
//   NCH result channels. Replaces fixed-delay run control with deterministic
//   termination. Synthesisable.
// PARAMETERS
//   ADDR_W      8     program counter width
//   DATA_W      32    width of one result channel
//   NCH         2     number of result channels captured at run end (>=1)
//   HALT_ADDR   9     fetch address that terminates a run
//   STALL_LIMIT 4     consecutive identical-PC fetches that count as a loop (>=2)
//   TIMEOUT     1000  cycles in RUN before watchdog fires (< 2**CNT_W)
//   CNT_W       16    cycle/fetch counter width
// PORTS
//   clk       in   1            clock, rising edge
//   rst       in   1            synchronous reset, active low
//   start     in   1            start run; sampled in IDLE or DONE only
//   pc        in   ADDR_W       core fetch address
//   pc_valid  in   1            fetch occurs this cycle
//   data      in   NCH*DATA_W   result channels, ch0 in LSBs
//   cpu_run   out  1            core run enable
//   busy      out  1            high in RUN and CAPTURE
//   done      out  1            high in DONE
//   status    out  2            00 none, 01 halt, 10 loop, 11 timeout
//   cycles    out  CNT_W        cycles spent in RUN
//   fetches   out  CNT_W        pc_valid cycles during RUN
//   result    out  NCH*DATA_W   snapshot of data taken in CAPTURE
// BEHAVIOUR
//   - Reset (rst==0 at clk edge): state IDLE; every output 0; internal
//     last_pc and stall_cnt cleared. Applies from any state, including mid-run.
//   - FSM: IDLE -> RUN on start. RUN -> CAPTURE on a terminate event.
//     CAPTURE -> DONE unconditionally after 1 cycle.
//     DONE -> RUN on start; otherwise DONE holds.
//   - Entering RUN: cycles, fetches, stall_cnt, status cleared;
//     result keeps its previous value until the next CAPTURE.
//   - cpu_run is 1 exactly in RUN. Start at edge k: cpu_run=1 from edge k+1.
//   - In RUN, each cycle: cycles+=1.
//     If pc_valid: fetches+=1.
//     If pc_valid and pc==last_pc: stall_cnt+=1.
//     If pc_valid and pc!=last_pc: stall_cnt=1.
//     On pc_valid, last_pc is updated.
//   - Terminate conditions, evaluated on current inputs/counts in RUN:
//       HALT: pc_valid && pc==HALT_ADDR
//       LOOP: pc_valid && pc==last_pc && stall_cnt+1==STALL_LIMIT
//       TOUT: cycles+1==TIMEOUT
//     The qualifying cycle is still counted. Simultaneous events:
//     priority HALT > LOOP > TOUT. status is written on the RUN->CAPTURE edge.
//   - The first fetch of a run never counts as a stall (last_pc is marked
//     invalid on RUN entry).
//   - CAPTURE: cpu_run=0. result<=data at the CAPTURE->DONE edge. Counters frozen.
//   - DONE: counters, status and result held stable.
//   - Latency: terminate event seen at edge n -> CAPTURE at n+1 -> DONE and
//     result valid at n+2.
//   - start is ignored in RUN and CAPTURE. pc/pc_valid are ignored outside RUN.
//   - Counters saturate at all-ones; they never wrap.
// TESTING
//   1 Reset mid-run: rst=0 while in RUN with cycles=37.
//     -> next edge: all outputs 0, IDLE; later start runs normally.
//   2 Halt: pc sequence 0..9, one fetch/cycle.
//     -> status=01, fetches=10, cycles=10; data=4123481/9402102 on ch0/ch1
//        appear in result; done 2 cycles after pc=9 fetch.
//   3 Loop: pc 0,1,5,5,5,5 with STALL_LIMIT=4.
//     -> status=10 on 4th consecutive 5; fetches=6.
//   4 Timeout: TIMEOUT=20, pc never 9, no repeats.
//     -> status=11, cycles=20, cpu_run low from cycle 21.
//   5 Priority: pc=9 repeated to reach STALL_LIMIT on cycle TIMEOUT
//     -> status=01.
//   6 Restart from DONE: second start.
//     -> counters restart at 0, old result held until new CAPTURE;
//        start pulses during RUN have no effect.

Source files
------------

// File: rtl/run_monitor.sv
// run_monitor
//   Execution monitor for the PseudoCPU top level. Gates the core run enable,
//   counts RUN cycles and fetches, and ends a run on the first of three events:
//   a fetch from HALT_ADDR, a self-loop of STALL_LIMIT identical fetches, or a
//   watchdog timeout. One cycle after a run ends, NCH result channels are
//   snapshotted.
//
//   Ports
//     clk_i       clock, rising edge
//     rst_ni      synchronous reset, active low
//     start_i     start a run; only honoured in IDLE or DONE
//     pc_i        core fetch address
//     pc_valid_i  a fetch happens this cycle
//     data_i      result channels, ch0 in the LSBs
//     cpu_run_o   core run enable, high exactly in RUN
//     busy_o      high in RUN and CAPTURE
//     done_o      high in DONE
//     status_o    00 none, 01 halt, 10 loop, 11 timeout
//     cycles_o    cycles spent in RUN (saturating)
//     fetches_o   pc_valid cycles during RUN (saturating)
//     result_o    snapshot of data_i taken in CAPTURE
module run_monitor #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NCH         = 2,
  parameter int HALT_ADDR   = 9,
  parameter int STALL_LIMIT = 4,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     pc_i,
  input  logic                  pc_valid_i,
  input  logic [NCH*DATA_W-1:0] data_i,
  output logic                  cpu_run_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            status_o,
  output logic [CNT_W-1:0]      cycles_o,
  output logic [CNT_W-1:0]      fetches_o,
  output logic [NCH*DATA_W-1:0] result_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [1:0] STAT_NONE = 2'b00;
  localparam logic [1:0] STAT_HALT = 2'b01;
  localparam logic [1:0] STAT_LOOP = 2'b10;
  localparam logic [1:0] STAT_TOUT = 2'b11;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e                  state_q;
  logic                    cpu_run_q, busy_q, done_q;
  logic [1:0]              status_q;
  logic [CNT_W-1:0]        cycles_q, fetches_q, stall_q;
  logic [ADDR_W-1:0]       last_pc_q;
  logic                    last_pc_vld_q;
  logic [NCH*DATA_W-1:0]   result_q;

  logic [CNT_W-1:0]        cycles_d, fetches_d, stall_d;
  logic                    same_pc_s, halt_s, loop_s, tout_s;
  logic [1:0]              term_code_s;

  // Next counter values and terminate detection for the current RUN cycle.
  always_comb begin
    cycles_d    = sat_inc(cycles_q);
    fetches_d   = sat_inc(fetches_q);
    // last_pc is invalid right after RUN entry so the first fetch never stalls.
    same_pc_s   = last_pc_vld_q && (pc_i == last_pc_q);
    stall_d     = same_pc_s ? sat_inc(stall_q) : {{(CNT_W-1){1'b0}}, 1'b1};
    halt_s      = pc_valid_i && (pc_i == ADDR_W'(HALT_ADDR));
    loop_s      = pc_valid_i && same_pc_s && (stall_d == CNT_W'(STALL_LIMIT));
    tout_s      = (cycles_d == CNT_W'(TIMEOUT));
    term_code_s = STAT_NONE;
    if (halt_s) begin
      term_code_s = STAT_HALT;
    end else if (loop_s) begin
      term_code_s = STAT_LOOP;
    end else if (tout_s) begin
      term_code_s = STAT_TOUT;
    end else begin
      term_code_s = STAT_NONE;
    end
  end

  // Run-control FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cpu_run_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= STAT_NONE;
      cycles_q      <= {CNT_W{1'b0}};
      fetches_q     <= {CNT_W{1'b0}};
      stall_q       <= {CNT_W{1'b0}};
      last_pc_q     <= {ADDR_W{1'b0}};
      last_pc_vld_q <= 1'b0;
      result_q      <= {(NCH*DATA_W){1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            // Fresh run: clear run statistics, keep the old result.
            state_q       <= ST_RUN;
            cpu_run_q     <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            status_q      <= STAT_NONE;
            cycles_q      <= {CNT_W{1'b0}};
            fetches_q     <= {CNT_W{1'b0}};
            stall_q       <= {CNT_W{1'b0}};
            last_pc_vld_q <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        ST_RUN: begin
          // The terminating cycle itself is still counted.
          cycles_q <= cycles_d;
          if (pc_valid_i) begin
            fetches_q     <= fetches_d;
            stall_q       <= stall_d;
            last_pc_q     <= pc_i;
            last_pc_vld_q <= 1'b1;
          end else begin
            fetches_q <= fetches_q;
          end
          if (term_code_s != STAT_NONE) begin
            state_q   <= ST_CAPTURE;
            cpu_run_q <= 1'b0;
            status_q  <= term_code_s;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_CAPTURE: begin
          state_q  <= ST_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= data_i;
        end
        default: begin
          state_q   <= ST_IDLE;
          cpu_run_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_run_o = cpu_run_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign status_o  = status_q;
  assign cycles_o  = cycles_q;
  assign fetches_o = fetches_q;
  assign result_o  = result_q;

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor
//   Directed bench for run_monitor (TIMEOUT overridden to 40 so that a run of
//   37 cycles can be interrupted by reset). Inputs change 1 time unit after
//   the rising edge and outputs are sampled at the same point.
module tb_run_monitor;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int NCH     = 2;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 40;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [ADDR_W-1:0]     pc;
  logic                  pc_valid;
  logic [NCH*DATA_W-1:0] data;
  logic                  cpu_run, busy, done;
  logic [1:0]            status;
  logic [CNT_W-1:0]      cycles, fetches;
  logic [NCH*DATA_W-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [63:0] data_a, data_b;

  run_monitor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH), .HALT_ADDR(9),
    .STALL_LIMIT(4), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pc_i(pc),
    .pc_valid_i(pc_valid), .data_i(data), .cpu_run_o(cpu_run),
    .busy_o(busy), .done_o(done), .status_o(status), .cycles_o(cycles),
    .fetches_o(fetches), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input int a);
    pc       = ADDR_W'(a);
    pc_valid = 1'b1;
    tick();
  endtask

  task automatic idle_cycle();
    pc_valid = 1'b0;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    data_a   = {32'd9402102, 32'd4123481};
    data_b   = 64'h1234_5678_DEAD_BEEF;
    rst_n    = 1'b0;
    start    = 1'b0;
    pc       = '0;
    pc_valid = 1'b0;
    data     = '0;
    tick();
    tick();
    chk("rst_cpu_run", 64'(cpu_run), 64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_status",  64'(status),  64'd0);
    chk("rst_cycles",  64'(cycles),  64'd0);
    chk("rst_result",  result,       64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_cpu_run", 64'(cpu_run), 64'd0);

    // 1: reset while running with cycles=37
    do_start();
    chk("t1_cpu_run", 64'(cpu_run), 64'd1);
    chk("t1_busy",    64'(busy),    64'd1);
    repeat (37) idle_cycle();
    chk("t1_cycles37", 64'(cycles), 64'd37);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t1_rst_cpu_run", 64'(cpu_run), 64'd0);
    chk("t1_rst_busy",    64'(busy),    64'd0);
    chk("t1_rst_cycles",  64'(cycles),  64'd0);
    tick();
    chk("t1_idle_stays",  64'(cpu_run), 64'd0);

    // 2: halt at pc 9 after 0..9
    data = data_a;
    do_start();
    for (int i = 0; i <= 9; i++) begin
      if (i == 9) chk("t2_run_before_halt", 64'(cpu_run), 64'd1);
      fetch(i);
    end
    pc_valid = 1'b0;
    chk("t2_cap_cpu_run", 64'(cpu_run), 64'd0);
    chk("t2_cap_busy",    64'(busy),    64'd1);
    chk("t2_cap_done",    64'(done),    64'd0);
    chk("t2_status",      64'(status),  64'd1);
    chk("t2_cycles",      64'(cycles),  64'd10);
    chk("t2_fetches",     64'(fetches), 64'd10);
    tick();
    chk("t2_done",   64'(done), 64'd1);
    chk("t2_busy",   64'(busy), 64'd0);
    chk("t2_result", result,    data_a);
    // DONE holds; pc and data activity must be ignored
    data = data_b;
    fetch(9);
    fetch(9);
    pc_valid = 1'b0;
    chk("t2_hold_result",  result,        data_a);
    chk("t2_hold_status",  64'(status),   64'd1);
    chk("t2_hold_fetches", 64'(fetches),  64'd10);
    chk("t2_hold_done",    64'(done),     64'd1);

    // 3 + 6: restart from DONE, loop on pc 5, start pulse mid-run ignored
    do_start();
    chk("t3_cycles0",   64'(cycles),  64'd0);
    chk("t3_fetches0",  64'(fetches), 64'd0);
    chk("t3_status0",   64'(status),  64'd0);
    chk("t3_done0",     64'(done),    64'd0);
    chk("t3_old_result", result,      data_a);
    fetch(0);
    start = 1'b1;
    fetch(1);
    start = 1'b0;
    fetch(5);
    fetch(5);
    fetch(5);
    chk("t3_no_early_loop", 64'(cpu_run), 64'd1);
    chk("t3_fetches_mid",   64'(fetches), 64'd5);
    fetch(5);
    pc_valid = 1'b0;
    chk("t3_status",  64'(status),  64'd2);
    chk("t3_fetches", 64'(fetches), 64'd6);
    chk("t3_cycles",  64'(cycles),  64'd6);
    chk("t3_cap_result_old", result, data_a);
    tick();
    chk("t3_result_new", result, data_b);

    // first fetch after RUN entry is not a stall even if it equals the old last pc
    do_start();
    fetch(5);
    fetch(5);
    fetch(5);
    chk("t3b_first_not_stall", 64'(cpu_run), 64'd1);
    fetch(5);
    pc_valid = 1'b0;
    chk("t3b_status",  64'(status),  64'd2);
    chk("t3b_fetches", 64'(fetches), 64'd4);
    tick();

    // 4: timeout with distinct pcs, never 9
    do_start();
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i == TIMEOUT - 1) chk("t4_run_at_39", 64'(cpu_run), 64'd1);
      fetch(i + 10);
    end
    pc_valid = 1'b0;
    chk("t4_status",  64'(status),  64'd3);
    chk("t4_cycles",  64'(cycles),  64'd40);
    chk("t4_fetches", 64'(fetches), 64'd40);
    chk("t4_cpu_run", 64'(cpu_run), 64'd0);
    tick();
    chk("t4_done",    64'(done),    64'd1);

    // 5a: HALT on the timeout cycle wins
    do_start();
    repeat (TIMEOUT - 1) idle_cycle();
    fetch(9);
    pc_valid = 1'b0;
    chk("t5a_status",  64'(status),  64'd1);
    chk("t5a_cycles",  64'(cycles),  64'd40);
    chk("t5a_fetches", 64'(fetches), 64'd1);
    tick();

    // 5b: LOOP on the timeout cycle wins over TOUT
    do_start();
    repeat (TIMEOUT - 4) idle_cycle();
    repeat (4) fetch(5);
    pc_valid = 1'b0;
    chk("t5b_status",  64'(status),  64'd2);
    chk("t5b_cycles",  64'(cycles),  64'd40);
    chk("t5b_fetches", 64'(fetches), 64'd4);
    tick();
    chk("t5b_done", 64'(done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
